dbus_timer_slave: RTL and testbench

- Data bus responder (slave) for the single-cycle write / addressed-read dbus protocol used by the lab testbenches and top levels.
- Decodes Addr and Wr, and holds a small register map:
  - control and scratch registers
  - a prescaled up-counter with compare match
  - a sticky status register driving an interrupt line
- Sits on the dbus opposite the bus master and returns read data combinationally on Dout.

---
 rtl/dbus_timer_slave.sv | 190 +++++++++++++++++++
 tb/tb_dbus_timer_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_timer_slave
//  Purpose  : dbus register slave. It holds control and scratch registers, a
//             prescaled up-counter with compare match, and a sticky status
//             register that drives an interrupt line. Read data is returned
//             combinationally and writes commit on the rising edge of Clk.
//  Options  : DBUS_WR_ERR_EN adds STATUS[1] (ERR). ERR is set by writes to
//             CNT or to unmapped addresses. This option also adds an ID
//             constant at address 0x07.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_timer_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] Din,
  output logic [DATA_WIDTH-1:0] Dout,
  input  logic                  Wr,
  output logic                  Irq
);

  // Register addresses; the full address is decoded so nothing aliases.
  localparam logic [ADDR_WIDTH-1:0] c_addr_ctrl    = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] c_addr_presc   = ADDR_WIDTH'(8'h01);
  localparam logic [ADDR_WIDTH-1:0] c_addr_cnt     = ADDR_WIDTH'(8'h02);
  localparam logic [ADDR_WIDTH-1:0] c_addr_cmp     = ADDR_WIDTH'(8'h03);
  localparam logic [ADDR_WIDTH-1:0] c_addr_status  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] c_addr_scratch = ADDR_WIDTH'(8'h05);

  localparam logic [DATA_WIDTH-1:0] c_one      = DATA_WIDTH'(1);
  // CTRL bit 1 (CLR) is a command and is never stored.
  localparam logic [DATA_WIDTH-1:0] c_clr_mask = DATA_WIDTH'(2);

`ifdef DBUS_WR_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] c_addr_id  = ADDR_WIDTH'(8'h07);
  localparam logic [DATA_WIDTH-1:0] c_id_value = DATA_WIDTH'(8'hA5);
`endif

  // Architectural state
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_presc;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic [DATA_WIDTH-1:0] r_psc;
  logic                  r_match;
`ifdef DBUS_WR_ERR_EN
  logic                  r_err;
`endif

  // Decode and datapath wires
  logic                  w_wr_ctrl;
  logic                  w_wr_presc;
  logic                  w_wr_cmp;
  logic                  w_wr_status;
  logic                  w_wr_scratch;
  logic                  w_clr;
  logic                  w_en;
  logic                  w_psc_hit;
  logic                  w_tick;
  logic [DATA_WIDTH-1:0] w_cnt_inc;
  logic                  w_match_set;
  logic [DATA_WIDTH-1:0] w_status;

  assign w_wr_ctrl    = Wr & (Addr == c_addr_ctrl);
  assign w_wr_presc   = Wr & (Addr == c_addr_presc);
  assign w_wr_cmp     = Wr & (Addr == c_addr_cmp);
  assign w_wr_status  = Wr & (Addr == c_addr_status);
  assign w_wr_scratch = Wr & (Addr == c_addr_scratch);

  // CLR is self-clearing. It overrides any tick on the same edge.
  assign w_clr       = w_wr_ctrl & Din[1];
  assign w_en        = r_ctrl[0];
  assign w_psc_hit   = (r_psc == r_presc);
  assign w_tick      = w_en & w_psc_hit;
  assign w_cnt_inc   = r_cnt + c_one;
  // Only a tick can raise MATCH. Writing CMP to equal CNT does not raise it.
  assign w_match_set = w_tick & ~w_clr & (w_cnt_inc == r_cmp);

  assign Irq = r_match & r_ctrl[2];

  // CTRL storage; the CLR bit is stripped so it always reads 0
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= Din & ~c_clr_mask;
    end
  end

  // PRESC, CMP and SCRATCH are plain R/W registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_presc   <= '0;
      r_cmp     <= '0;
      r_scratch <= '0;
    end else begin
      if (w_wr_presc)   r_presc   <= Din;
      if (w_wr_cmp)     r_cmp     <= Din;
      if (w_wr_scratch) r_scratch <= Din;
    end
  end

  // Prescaler: counts while enabled and returns to 0 on a tick. After a
  // PRESC write it may sit above the new limit; it then wraps naturally.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_psc <= '0;
    end else if (w_clr) begin
      r_psc <= '0;
    end else if (w_en) begin
      r_psc <= w_psc_hit ? '0 : (r_psc + c_one);
    end
  end

  // Counter: advances once per tick and wraps from all-ones to zero
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (w_clr) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Sticky MATCH flag; a new match beats a write-1-to-clear on the same edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_match <= 1'b0;
    end else if (w_match_set) begin
      r_match <= 1'b1;
    end else if (w_wr_status & Din[0]) begin
      r_match <= 1'b0;
    end
  end

`ifdef DBUS_WR_ERR_EN
  logic w_bad_wr;

  // A write is illegal if it targets CNT or any address outside the map.
  // The ID address is read-only and is deliberately excluded from this check.
  assign w_bad_wr = Wr & ~(Addr == c_addr_ctrl)  & ~(Addr == c_addr_presc)
                       & ~(Addr == c_addr_cmp)   & ~(Addr == c_addr_status)
                       & ~(Addr == c_addr_scratch) & ~(Addr == c_addr_id);

  // Sticky ERR flag; a new error beats a write-1-to-clear on the same edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad_wr) begin
      r_err <= 1'b1;
    end else if (w_wr_status & Din[1]) begin
      r_err <= 1'b0;
    end
  end
`endif

  // Assemble STATUS from the individual flag bits
  always_comb begin
    w_status    = '0;
    w_status[0] = r_match;
`ifdef DBUS_WR_ERR_EN
    w_status[1] = r_err;
`endif
  end

  // Combinational read mux; unmapped addresses read 0
  always_comb begin
    Dout = '0;
    case (Addr)
      c_addr_ctrl:    Dout = r_ctrl;
      c_addr_presc:   Dout = r_presc;
      c_addr_cnt:     Dout = r_cnt;
      c_addr_cmp:     Dout = r_cmp;
      c_addr_status:  Dout = w_status;
      c_addr_scratch: Dout = r_scratch;
`ifdef DBUS_WR_ERR_EN
      c_addr_id:      Dout = c_id_value;
`endif
      default:        Dout = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbus_timer_slave
//  Purpose  : Self-checking bench for dbus_timer_slave. Each scenario task
//             drives the bus and queues expected register reads. It then
//             drains the queue by reading the DUT and comparing inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_timer_slave;

  logic       Clk;
  logic       Rst_n;
  logic [7:0] Addr;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic       Wr;
  logic       Irq;

  int n_total;
  int n_pass;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  dbus_timer_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Addr  (Addr),
    .Din   (Din),
    .Dout  (Dout),
    .Wr    (Wr),
    .Irq   (Irq)
  );

  // Long period so a burst of #1-spaced reads never crosses a rising edge
  initial Clk = 1'b0;
  always #50 Clk = ~Clk;

  // Called at a falling edge; exactly one rising edge commits the write
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    Addr = a; Din = d; Wr = 1'b1;
    @(negedge Clk);
    Wr = 1'b0; Din = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] e, input string n);
    exp_t t;
    t.addr = a; t.exp = e; t.name = n;
    sb.push_back(t);
  endtask

  task automatic test_reset;
    // Build up live state with a pending interrupt, then reset mid-run
    wr(8'h05, 8'h55);
    wr(8'h01, 8'h00);
    wr(8'h03, 8'h02);
    wr(8'h00, 8'h05);
    idle(3);
    n_total++;
    if (Irq !== 1'b1) $display("FAIL irq_before_reset: got %b want 1", Irq);
    else n_pass++;
    #7 Rst_n = 1'b0;
    for (int a = 0; a < 8; a++) begin
`ifdef DBUS_WR_ERR_EN
      push(8'(a), (a == 7) ? 8'hA5 : 8'h00, "reset_read");
`else
      push(8'(a), 8'h00, "reset_read");
`endif
    end
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    n_total++;
    if (Irq !== 1'b0) $display("FAIL irq_in_reset: got %b want 0", Irq);
    else n_pass++;
    @(negedge Clk);
    Rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_readback;
    wr(8'h05, 8'h3C); push(8'h05, 8'h3C, "scratch");
    wr(8'h01, 8'h07); push(8'h01, 8'h07, "presc");
    wr(8'h03, 8'h10); push(8'h03, 8'h10, "cmp");
    wr(8'h02, 8'hFF); push(8'h02, 8'h00, "cnt_ro");
    wr(8'h06, 8'h12); push(8'h06, 8'h00, "unmapped");
    push(8'h05, 8'h3C, "scratch_kept");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_prescale;
    wr(8'h01, 8'h03);
    wr(8'h00, 8'h01);           // EN is active from the next edge on
    idle(40);                   // 40 edges / (3+1) = 10 ticks
    push(8'h02, 8'd10, "cnt_presc3");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h00, 8'h03);
    push(8'h02, 8'h00, "cnt_after_clr");
    push(8'h00, 8'h01, "ctrl_clr_reads0");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h00, 8'h02);           // stop and clear: CNT=0, prescaler=0, CTRL=0
  endtask

  task automatic test_match_irq;
    wr(8'h01, 8'h00);
    wr(8'h03, 8'h05);
    wr(8'h00, 8'h05);           // one increment per edge from now on
    idle(4);
    push(8'h02, 8'h04, "cnt4");
    push(8'h04, 8'h00, "status_pre");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    n_total++;
    if (Irq !== 1'b0) $display("FAIL irq_pre_match: got %b want 0", Irq);
    else n_pass++;
    idle(1);
    n_total++;
    if (Irq !== 1'b1) $display("FAIL irq_on_match: got %b want 1", Irq);
    else n_pass++;
    push(8'h02, 8'h05, "cnt5");
    push(8'h04, 8'h01, "status_match");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h04, 8'h01);           // CNT -> 6 on this edge, MATCH cleared
    n_total++;
    if (Irq !== 1'b0) $display("FAIL irq_after_w1c: got %b want 0", Irq);
    else n_pass++;
    idle(254);                  // 6 + 254 wraps to 4
    push(8'h02, 8'h04, "cnt_wrapped");
    push(8'h04, 8'h00, "status_wrapped");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    idle(1);
    push(8'h04, 8'h01, "status_rematch");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_precedence;
    wr(8'h04, 8'h01);           // CNT 5->6, MATCH cleared
    idle(254);                  // CNT = 4
    wr(8'h04, 8'h01);           // W1C on the 4->5 match edge: set wins
    push(8'h04, 8'h01, "w1c_vs_set");
    push(8'h02, 8'h05, "cnt_at_set");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h04, 8'h01);           // CNT 6, MATCH cleared
    wr(8'h03, 8'h0A);           // CNT 7
    idle(2);                    // CNT 9; next tick would match 10
    wr(8'h00, 8'h07);           // CLR on that tick edge
    push(8'h02, 8'h00, "clr_vs_tick");
    push(8'h04, 8'h00, "clr_no_match");
    push(8'h00, 8'h05, "ctrl_after_clr");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h00, 8'h04);           // last tick: CNT 0->1, then EN=0
    wr(8'h03, 8'h01);           // CMP := CNT must not raise MATCH
    push(8'h02, 8'h01, "cnt_held");
    push(8'h04, 8'h00, "cmp_eq_no_match");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
  endtask

  task automatic test_err_flag;
`ifdef DBUS_WR_ERR_EN
    wr(8'h02, 8'h11); push(8'h04, 8'h02, "err_cnt_wr");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h04, 8'h02); push(8'h04, 8'h00, "err_w1c");
    wr(8'h20, 8'h00); push(8'h04, 8'h02, "err_unmapped");
    push(8'h07, 8'hA5, "id_reg");
`else
    wr(8'h02, 8'h11); push(8'h04, 8'h00, "no_err_cnt_wr");
    wr(8'h20, 8'h00); push(8'h04, 8'h00, "no_err_unmapped");
    push(8'h07, 8'h00, "no_id_reg");
`endif
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
    wr(8'h04, 8'h02);
    wr(8'h05, 8'h99);
    wr(8'h07, 8'h00);
    push(8'h04, 8'h00, "no_err_legal_wr");
    push(8'h05, 8'h99, "scratch_legal_wr");
    while (sb.size() > 0) begin
      exp_t t = sb.pop_front();
      Addr = t.addr; #1;
      n_total++;
      if (Dout !== t.exp) $display("FAIL %s[%0h]: got %h want %h", t.name, t.addr, Dout, t.exp);
      else n_pass++;
    end
  endtask

  // Watchdog so the bench always ends on its own
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

  initial begin
    n_total = 0; n_pass = 0;
    Rst_n = 1'b0; Addr = 8'h00; Din = 8'h00; Wr = 1'b0;
    idle(2);
    Rst_n = 1'b1;
    idle(1);
    test_reset;
    test_readback;
    test_prescale;
    test_match_irq;
    test_precedence;
    test_err_flag;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
